clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of each channel's divide value and counter.
REQ-003 Parameter DEF_DIV, default 1, divide value loaded into every channel at reset.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 cfg_valid  input  1  divide-value write request.
REQ-008 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-009 cfg_div  input  CNT_W  new divide value N; tick period is N+1 cycles.
REQ-010 cfg_ready  output  1  write acceptance, combinational.
REQ-011 tick  output  NUM_CH  registered one-cycle clock-enable pulse per channel.
REQ-012 sq  output  NUM_CH  registered square wave, period 2(N+1) cycles, 50% duty.

Function
REQ-013 Each channel SHALL hold an active value div_act, a pending value div_pend, a pending flag pend, and a down-counter cnt.
REQ-014 Write accepted when cfg_valid and cfg_ready are high at a clock edge.
REQ-015 cfg_ready = !pend[cfg_ch]; for cfg_ch >= NUM_CH, cfg_ready = 1 and the write is discarded.
REQ-016 Accepted write to an enabled channel: div_pend <= cfg_div, pend <= 1; active value unchanged until terminal count.
REQ-017 Accepted write to a disabled channel: div_act <= cfg_div and cnt <= cfg_div immediately; pend stays 0.
REQ-018 Channel with en low at an edge: cnt <= div_act (or div_pend if pend, then div_act <= div_pend, pend <= 0), tick <= 0, sq holds.
REQ-019 Channel with en high and cnt != 0: cnt <= cnt-1, tick <= 0.
REQ-020 Channel with en high and cnt == 0 (terminal count): tick <= 1, sq <= ~sq, cnt <= reload value.
REQ-021 Reload value = div_pend if pend, else div_act; on pend, div_act <= div_pend and pend <= 0 on the same edge.
REQ-022 First tick appears N+1 cycles after the first edge with en sampled high; thereafter exactly every N+1 cycles, no glitch or short period on ratio change.
REQ-023 N = 0: tick held high every cycle while enabled; sq toggles every cycle (clk/2).
REQ-024 N = 2^CNT_W-1: period 2^CNT_W cycles; counter SHALL not wrap below 0.
REQ-025 Write and terminal count on the same edge for the same channel: the terminal-count reload uses the old value; new value becomes pending, applied at the next terminal count.
REQ-026 Channels fully independent; only one write per cycle across all channels.

Reset
REQ-027 rst_n low SHALL asynchronously set cnt = DEF_DIV, div_act = DEF_DIV, div_pend = 0, pend = 0, tick = 0, sq = 0 for all channels.
REQ-028 Reset mid-period discards pending values; operation resumes per REQ-022 after rst_n rises.

Configuration
REQ-029 Macro CLKDIV_SYNC_EN defined: adds input sync_in (1 bit); sync_in high at an edge forces every channel cnt <= reload value (pending applied), tick <= 0, sq <= 0, overriding REQ-019/020; all channels then phase-aligned.
REQ-030 CLKDIV_SYNC_EN undefined: no sync_in port; behaviour identical to sync_in held at 0.

Verification
REQ-031 Reset, en=4'b0001, DEF_DIV=1 -> tick[0] pulses every 2 cycles, sq[0] period 4, other channels tick=0.
REQ-032 Channel 1 enabled, write N=4 while disabled, then en[1]=1 -> first tick[1] 5 cycles after enable, then every 5.
REQ-033 Channel 0 running N=3, write N=9 mid-period -> current period stays 4 cycles, next period 10; second write before apply sees cfg_ready=0.
REQ-034 Write N=0 to channel 2 and enable -> tick[2] constant 1, sq[2] toggles every cycle; write cfg_ch=5 with NUM_CH=4 -> accepted, no effect.
REQ-035 Assert rst_n low mid-period with pend=1 -> tick/sq drop to 0 immediately, pending value lost, DEF_DIV period after release.
REQ-036 With CLKDIV_SYNC_EN, channels at N=2 and N=5 pulse sync_in -> both restart, ticks coincide every 6 cycles from sync.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider: per-channel tick pulse every N+1 cycles plus a 50% square wave.
// Optional macro CLKDIV_SYNC_EN adds a sync_in port that restarts and phase-aligns every channel.
module clk_div_multi #(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 16,
  parameter  int DEF_DIV = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  div_act  [NUM_CH];
  logic [CNT_W-1:0]  div_pend [NUM_CH];
  logic [CNT_W-1:0]  reload   [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] term;
  logic              sync_i;

`ifdef CLKDIV_SYNC_EN
  assign sync_i = sync_in;
`else
  assign sync_i = 1'b0;
`endif

  // Out-of-range channel numbers match no channel, so they stay ready and the write falls on the floor.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      reload[i] = pend[i] ? div_pend[i] : div_act[i];
      wr_hit[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      term[i]   = en[i] && (cnt[i] == '0);
    end
  end

  // NOTE: these arrays are a handful of flops per channel, not a RAM, so resetting them is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= CNT_W'(DEF_DIV);
        div_act[i]  <= CNT_W'(DEF_DIV);
        div_pend[i] <= '0;
      end
      pend <= '0;
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Reload on sync, while idle, or at terminal count; otherwise count down.
        if (sync_i || !en[i] || term[i]) begin
          cnt[i]     <= reload[i];
          div_act[i] <= reload[i];
          pend[i]    <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end

        tick[i] <= term[i] && !sync_i;

        if (sync_i)       sq[i] <= 1'b0;
        else if (term[i]) sq[i] <= ~sq[i];

        // NOTE: a later non-blocking assignment to the same flop wins, so a write overrides the reload above.
        if (wr_hit[i]) begin
          if (en[i]) begin
            div_pend[i] <= cfg_div;
            pend[i]     <= 1'b1;
          end else begin
            div_act[i] <= cfg_div;
            cnt[i]     <= cfg_div;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: deadline-based reference model compared every cycle, plus directed literal checks.
// Exercises sync_in as well when CLKDIV_SYNC_EN is defined.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int CW  = 4;
  localparam int DEF = 1;
  localparam int CHW = 3;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic [NCH-1:0] en        = '0;
  logic           cfg_valid = 1'b0;
  logic [CHW-1:0] cfg_ch    = '0;
  logic [CW-1:0]  cfg_div   = '0;
  logic           cfg_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
`ifdef CLKDIV_SYNC_EN
  logic sync_in = 1'b0;
  wire  sync_b  = sync_in;
`else
  wire  sync_b  = 1'b0;
`endif

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .sq        (sq)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: each channel keeps the absolute edge number at which its next tick is due.
  int             m_act  [NCH];
  int             m_pn   [NCH];
  int             m_next [NCH];
  bit [NCH-1:0]   m_pend, m_tick, m_sq;
  bit             m_fresh;
  int             edge_no = 0;

  function automatic bit model_ready(input logic [CHW-1:0] ch);
    if (int'(ch) >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i]  = DEF;
      m_pn[i]   = 0;
      m_next[i] = 0;
    end
    m_pend  = '0;
    m_tick  = '0;
    m_sq    = '0;
    m_fresh = 1'b1;
  endtask

  task automatic model_edge();
    bit acc;
    int rl;
    acc = cfg_valid && model_ready(cfg_ch);
    edge_no++;
    for (int i = 0; i < NCH; i++) begin
      if (m_fresh) m_next[i] = edge_no + m_act[i];
      rl = m_pend[i] ? m_pn[i] : m_act[i];
      if (sync_b) begin
        m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        m_act[i] = rl; m_pend[i] = 1'b0; m_next[i] = edge_no + rl + 1;
      end else if (en[i]) begin
        if (edge_no == m_next[i]) begin
          m_tick[i] = 1'b1; m_sq[i] = ~m_sq[i];
          m_act[i] = rl; m_pend[i] = 1'b0; m_next[i] = edge_no + rl + 1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
        m_act[i] = rl; m_pend[i] = 1'b0; m_next[i] = edge_no + rl + 1;
      end
      if (acc && int'(cfg_ch) == i) begin
        if (en[i]) begin
          m_pn[i] = int'(cfg_div); m_pend[i] = 1'b1;
        end else begin
          m_act[i] = int'(cfg_div); m_next[i] = edge_no + int'(cfg_div) + 1;
        end
      end
    end
    m_fresh = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("tick_vs_model",  32'(tick),      32'(m_tick));
      check("sq_vs_model",    32'(sq),        32'(m_sq));
      check("ready_vs_model", 32'(cfg_ready), 32'(model_ready(cfg_ch)));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_tick(input int ch, input int budget, output time t);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (tick[ch] === 1'b1) begin
        t = $time;
        return;
      end
    end
    t = $time;
    chk_cnt++;
    $display("FAIL tick%0d_timeout: got no tick within %0d cycles, required one", ch, budget);
  endtask

  // Called at posedge+1; the write is sampled on the next edge.
  task automatic do_cfg(input int ch, input int div);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(div);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  function automatic int rise_idx(input time tp, input time t);
    return int'((t - 5 - tp) / 10);
  endfunction

  function automatic int gap(input time ta, input time tb);
    return int'((tb - ta) / 10);
  endfunction

  initial begin
    time tp, t0, t1, t2;

    #12;
    check("rst_tick",  32'(tick),      0);
    check("rst_sq",    32'(sq),        0);
    check("rst_ready", 32'(cfg_ready), 1);

    // Default divide value straight out of reset.
    @(posedge clk); tp = $time; #1;
    rst_n = 1'b1; en = 5'b00001;
    wait_tick(0, 10, t0);
    check("def_first_tick", rise_idx(tp, t0), 2);
    check("def_sq_first",   32'(sq[0]), 1);
    wait_tick(0, 10, t1);
    check("def_period",     gap(t0, t1), 2);
    check("def_sq_second",  32'(sq[0]), 0);
    check("def_others_idle", 32'(tick[4:1]), 0);

    // Write to an idle channel, then enable it.
    @(posedge clk); #1;
    do_cfg(1, 4);
    tp = $time - 1; en[1] = 1'b1;
    wait_tick(1, 20, t0);
    check("n4_first_tick", rise_idx(tp, t0), 5);
    wait_tick(1, 20, t1);
    check("n4_period", gap(t0, t1), 5);

    // Ratio change mid-period on a running channel.
    @(posedge clk); #1;
    en[0] = 1'b0;
    do_cfg(0, 3);
    tp = $time - 1; en[0] = 1'b1;
    wait_tick(0, 20, t0);
    check("n3_first_tick", rise_idx(tp, t0), 4);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 4'd9;
    #1 check("n9_ready_free", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_div = 4'd7;
    #1 check("n9_ready_busy", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    wait_tick(0, 20, t1);
    check("n9_old_period", gap(t0, t1), 4);
    wait_tick(0, 20, t2);
    check("n9_new_period", gap(t1, t2), 10);

    // N = 0: tick stuck high, sq at clk/2.
    @(posedge clk); #1;
    do_cfg(2, 0);
    tp = $time - 1; en[2] = 1'b1;
    wait_tick(2, 5, t0);
    check("n0_first_tick", rise_idx(tp, t0), 1);
    check("n0_sq_first",   32'(sq[2]), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("n0_tick_high", 32'(tick[2]), 1);
      check("n0_sq_toggle", 32'(sq[2]), (k % 2 == 0) ? 1 : 0);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 4'd7;
    #1 check("oob_ready", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;

    // Maximum divide value.
    do_cfg(3, 15);
    tp = $time - 1; en[3] = 1'b1;
    wait_tick(3, 40, t0);
    check("nmax_first_tick", rise_idx(tp, t0), 16);
    wait_tick(3, 40, t1);
    check("nmax_period", gap(t0, t1), 16);

    // Reset mid-period with a pending value.
    @(posedge clk); #1;
    do_cfg(0, 2);
    #2 check("rst_pend_ready", 32'(cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_tick", 32'(tick), 0);
    check("rst_async_sq",   32'(sq),   0);
    @(posedge clk); tp = $time; #1;
    rst_n = 1'b1;
    wait_tick(0, 20, t0);
    check("rst_resume_first", rise_idx(tp, t0), 2);
    wait_tick(0, 20, t1);
    check("rst_resume_period", gap(t0, t1), 2);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CHW'($urandom_range(0, 7));
      cfg_div   = ($urandom_range(0, 7) == 0) ? 4'd15 : CW'($urandom_range(0, 4));
`ifdef CLKDIV_SYNC_EN
      sync_in   = ($urandom_range(0, 63) == 0);
`endif
      if (it == 1500) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;

`ifdef CLKDIV_SYNC_EN
    // Sync aligns channels at N=2 and N=5.
    sync_in = 1'b0; en = '0;
    @(posedge clk); #1;
    do_cfg(0, 2);
    do_cfg(1, 5);
    en = 5'b00011;
    repeat (7) @(posedge clk);
    #1;
    tp = $time - 1; sync_in = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b0;
    wait_tick(1, 20, t0);
    check("sync_first_tick", rise_idx(tp, t0), 7);
    check("sync_coincide0",  32'(tick[0]), 1);
    wait_tick(1, 20, t1);
    check("sync_period",     gap(t0, t1), 6);
    check("sync_coincide1",  32'(tick[0]), 1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
